// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_unit
//  Description : Hazard/stall controller for the IF/ID pipeline buffer.
//                Detects load-use hazards and taken-branch flushes, sequences
//                multi-cycle stalls/flushes and keeps saturating event
//                counters for performance debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int         LOAD_STALL_CYCLES = 1,
    parameter int         FLUSH_CYCLES      = 1,
    parameter logic [3:0] OP_NOP            = 4'h0,
    parameter int         CNT_W             = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_opcode,
    input  logic [3:0]       id_src_a,
    input  logic [3:0]       id_src_b,
    input  logic             ex_mem_read,
    input  logic [3:0]       ex_dest,
    input  logic             br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Reload values are the number of cycles still owed after the first one.
    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] rem;
    logic [3:0] next_rem;
    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;

    // Register zero is hardwired, so a load into it can never conflict.
    assign load_use = ex_mem_read && (ex_dest != 4'h0) && (id_opcode != OP_NOP) &&
                      ((ex_dest == id_src_a) || (ex_dest == id_src_b));

    // State and remaining-cycle register; reset returns to RUN at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            rem   <= 4'd0;
        end else begin
            state <= next_state;
            rem   <= next_rem;
        end
    end

    // Next-state and same-cycle control outputs; a taken branch wins over everything.
    always_comb begin
        next_state  = state;
        next_rem    = rem;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            next_state  = RUN;
            next_rem    = 4'd0;
        end else if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                next_state = FLUSH;
                next_rem   = FLUSH_RELOAD;
            end else begin
                next_state = RUN;
                next_rem   = 4'd0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            next_state = STALL;
                            next_rem   = STALL_RELOAD;
                        end
                    end
                end
                STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (rem <= 4'd1) begin
                        next_state = RUN;
                        next_rem   = 4'd0;
                    end else begin
                        next_rem = rem - 4'd1;
                    end
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (rem <= 4'd1) begin
                        next_state = RUN;
                        next_rem   = 4'd0;
                    end else begin
                        next_rem = rem - 4'd1;
                    end
                end
                default: begin
                    next_state = RUN;
                    next_rem   = 4'd0;
                end
            endcase
        end
    end

    assign stall_inc = idex_bubble && !ifid_flush;
    assign flush_inc = ifid_flush;

    // Saturating performance counters; they never wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
